// File: rtl/ws2812_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_led_arbiter
// Purpose  : Shares one WS2812 status LED between NUM_SRC status sources.
//            Stretches short requests so they stay visible, picks the
//            highest-index live source, applies blink and brightness, and
//            drives the GRB colour word sampled by the WS2812 serial driver.
// Ports    : clk        - system clock
//            reset_n    - asynchronous reset, active low
//            src_req    - level request per source (bit i = source i)
//            src_color  - GRB colour of source i at [24*i +: 24]
//            src_blink  - 1 = source i is shown blinking
//            bright     - dimming shift applied to each colour byte
//            color      - colour word to the WS2812 driver
//            active     - 1 = some source is displayed
//            active_src - index of displayed source (0 when inactive)
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_led_arbiter #(
  parameter int          NUM_SRC    = 4,
  parameter int          CLK_FRE    = 28_375_160,
  parameter int          TICK_HZ    = 1000,
  parameter int          HOLD_MS    = 200,
  parameter int          BLINK_MS   = 250,
  parameter logic [23:0] IDLE_COLOR = 24'h000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [24*NUM_SRC-1:0]  src_color,
  input  logic [NUM_SRC-1:0]     src_blink,
  input  logic [2:0]             bright,
  output logic [23:0]            color,
  output logic                   active,
  output logic [2:0]             active_src
);

  localparam int C_PRESC_MAX = CLK_FRE / TICK_HZ - 1;
  localparam int C_PW        = (C_PRESC_MAX > 0) ? $clog2(C_PRESC_MAX + 1) : 1;
  localparam int C_HW        = $clog2(HOLD_MS + 1);
  localparam int C_BW        = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  localparam logic [C_PW-1:0] C_PRESC_LAST = C_PW'(C_PRESC_MAX);
  localparam logic [C_HW-1:0] C_HOLD_LOAD  = C_HW'(HOLD_MS);
  localparam logic [C_BW-1:0] C_BLINK_LAST = C_BW'(BLINK_MS - 1);

  // Per-byte right shift of a GRB word; discarded bits are simply dropped.
  function automatic logic [23:0] dim(input logic [23:0] c, input logic [2:0] s);
    dim = {c[23:16] >> s, c[15:8] >> s, c[7:0] >> s};
  endfunction

  logic [C_PW-1:0]   presc_q, presc_d;
  logic [C_HW-1:0]   hold_q [NUM_SRC];
  logic [C_HW-1:0]   hold_d [NUM_SRC];
  logic [2:0]        sel_q;
  logic              any_live_q;
  logic [C_BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [23:0]       color_q, color_d;
  logic              active_q, active_d;
  logic [2:0]        active_src_q, active_src_d;

  logic              w_tick;
  logic [NUM_SRC-1:0] w_live;
  logic [2:0]        w_sel;
  logic              w_any_live;
  logic              w_restart;
  logic [23:0]       w_sel_color;
  logic              w_sel_blink;

  // Timebase: one-cycle tick on the prescaler wrap.
  assign w_tick  = (presc_q == C_PRESC_LAST);
  assign presc_d = w_tick ? '0 : presc_q + 1'b1;

  // Hold counters: a live request reloads every cycle (load beats tick), so
  // the countdown only starts once the request drops.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      hold_d[i] = hold_q[i];
      if (src_req[i]) begin
        hold_d[i] = C_HOLD_LOAD;
      end else if (w_tick && (hold_q[i] != '0)) begin
        hold_d[i] = hold_q[i] - 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_live
      assign w_live[gi] = src_req[gi] | (hold_q[gi] != '0);
    end
  endgenerate

  // Highest live index wins.
  always_comb begin
    w_sel      = '0;
    w_any_live = |w_live;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_live[i]) w_sel = 3'(i);
    end
  end

  // A newly displayed source always starts in the lit phase, even if the
  // blink counter would wrap on the same cycle.
  assign w_restart = (w_sel != sel_q) || (w_any_live && !any_live_q);

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (w_restart) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (w_tick) begin
      if (blink_cnt_q == C_BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Mux the registered selection; loop form keeps the index in range for
  // any NUM_SRC.
  always_comb begin
    w_sel_color = '0;
    w_sel_blink = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_q == 3'(i)) begin
        w_sel_color = src_color[24*i +: 24];
        w_sel_blink = src_blink[i];
      end
    end
  end

  always_comb begin
    color_d      = dim(w_sel_color, bright);
    active_d     = any_live_q;
    active_src_d = any_live_q ? sel_q : 3'd0;
    if (!any_live_q) begin
      color_d = dim(IDLE_COLOR, bright);
    end else if (w_sel_blink && !phase_q) begin
      color_d = 24'h000000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q      <= '0;
      for (int i = 0; i < NUM_SRC; i++) hold_q[i] <= '0;
      sel_q        <= '0;
      any_live_q   <= 1'b0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      color_q      <= 24'h000000;
      active_q     <= 1'b0;
      active_src_q <= 3'd0;
    end else begin
      presc_q      <= presc_d;
      for (int i = 0; i < NUM_SRC; i++) hold_q[i] <= hold_d[i];
      sel_q        <= w_sel;
      any_live_q   <= w_any_live;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      color_q      <= color_d;
      active_q     <= active_d;
      active_src_q <= active_src_d;
    end
  end

  assign color      = color_q;
  assign active     = active_q;
  assign active_src = active_src_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_led_arbiter
// Purpose  : Self-checking bench for ws2812_led_arbiter. Every clock edge is
//            compared against a timeline model (tick edges, hold expiry and
//            blink phase derived arithmetically from edge indices), plus
//            table vectors and directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_led_arbiter;

  localparam int          NUM_SRC    = 4;
  localparam int          CLK_FRE    = 1000;
  localparam int          TICK_HZ    = 100;
  localparam int          HOLD_MS    = 20;
  localparam int          BLINK_MS   = 5;
  localparam logic [23:0] IDLE_COLOR = 24'h010203;
  localparam int          TPD        = CLK_FRE / TICK_HZ;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NUM_SRC-1:0]    src_req;
  logic [24*NUM_SRC-1:0] src_color;
  logic [NUM_SRC-1:0]    src_blink;
  logic [2:0]            bright;
  logic [23:0]           color;
  logic                  active;
  logic [2:0]            active_src;

  always #5 clk = ~clk;

  ws2812_led_arbiter #(
    .NUM_SRC(NUM_SRC), .CLK_FRE(CLK_FRE), .TICK_HZ(TICK_HZ),
    .HOLD_MS(HOLD_MS), .BLINK_MS(BLINK_MS), .IDLE_COLOR(IDLE_COLOR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_req(src_req), .src_color(src_color),
    .src_blink(src_blink), .bright(bright), .color(color), .active(active),
    .active_src(active_src)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: edge k = k-th rising edge since reset release. Ticks land on
  // edges that are multiples of TPD.
  int          k;
  int          last_hi [NUM_SRC];
  int          m_sel;
  bit          m_any;
  int          m_restart;
  logic [23:0] e_color;
  logic        e_active;
  logic [2:0]  e_src;

  function automatic logic [23:0] ref_dim(input logic [23:0] c, input int s);
    int g, r, b;
    g = ((c >> 16) & 255) >> s;
    r = ((c >> 8) & 255) >> s;
    b = (c & 255) >> s;
    return 24'(g * 65536 + r * 256 + b);
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < NUM_SRC; i++) last_hi[i] = -1;
    m_sel     = 0;
    m_any     = 1'b0;
    m_restart = 0;
  endtask

  // Predict the outputs right after the next edge from current inputs.
  task automatic model_edge();
    int new_sel, ticks;
    bit new_any, lv, lit;
    k++;
    new_sel = 0;
    new_any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lv = src_req[i];
      // hold left = HOLD_MS minus ticks seen after the last high sample
      if (!lv && last_hi[i] >= 0)
        lv = (HOLD_MS - ((k - 1) / TPD - last_hi[i] / TPD)) > 0;
      if (src_req[i]) last_hi[i] = k;
      if (lv) begin
        new_sel = i;
        new_any = 1'b1;
      end
    end
    ticks = (k - 1) / TPD - m_restart / TPD;
    lit   = ((ticks / BLINK_MS) % 2) == 0;
    if (!m_any)                         e_color = ref_dim(IDLE_COLOR, int'(bright));
    else if (src_blink[m_sel] && !lit)  e_color = 24'h000000;
    else                                e_color = ref_dim(src_color[24*m_sel +: 24], int'(bright));
    e_active = m_any;
    e_src    = m_any ? 3'(m_sel) : 3'd0;
    if ((new_sel != m_sel) || (new_any && !m_any)) m_restart = k;
    m_sel = new_sel;
    m_any = new_any;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    n_tests++;
    if (color !== e_color || active !== e_active || active_src !== e_src) begin
      n_fail++;
      $display("FAIL %s edge %0d: got color=%h active=%b src=%0d, expected color=%h active=%b src=%0d",
               tag, k, color, active, active_src, e_color, e_active, e_src);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_all();
    src_req = '0;
    repeat (230) step("clear");
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [2:0]  bri;
    logic [23:0] exp_color;
    logic [2:0]  exp_src;
    logic        exp_act;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit_n, dark_n, dur;
    bit seen;

    vecs[0] = '{4'b0001, 3'd0, 24'hFF8040, 3'd0, 1'b1};
    vecs[1] = '{4'b0001, 3'd3, 24'h1F1008, 3'd0, 1'b1};
    vecs[2] = '{4'b0001, 3'd7, 24'h010100, 3'd0, 1'b1};
    vecs[3] = '{4'b0101, 3'd0, 24'h123456, 3'd2, 1'b1};
    vecs[4] = '{4'b1111, 3'd0, 24'h0000FF, 3'd3, 1'b1};
    vecs[5] = '{4'b0110, 3'd1, 24'h091A2B, 3'd2, 1'b1};
    vecs[6] = '{4'b0000, 3'd0, 24'h010203, 3'd0, 1'b0};
    vecs[7] = '{4'b1010, 3'd2, 24'h00003F, 3'd3, 1'b1};
    vecs[8] = '{4'b0010, 3'd0, 24'h00FF00, 3'd1, 1'b1};

    // Reset with all requests high
    reset_n   = 1'b0;
    src_req   = 4'hF;
    src_color = {24'h0000FF, 24'h123456, 24'h00FF00, 24'hFF8040};
    src_blink = '0;
    bright    = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_color", 32'(color), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_src", 32'(active_src), 32'h0);
    src_req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step("rel");
    step("rel");
    check("idle_after_rst", 32'(color), 32'(IDLE_COLOR));

    // Steady-state priority and brightness vectors
    for (int v = 0; v < 9; v++) begin
      src_req = vecs[v].req;
      bright  = vecs[v].bri;
      repeat (3) step("vec");
      check($sformatf("vec%0d_color", v), 32'(color), 32'(vecs[v].exp_color));
      check($sformatf("vec%0d_src", v), 32'(active_src), 32'(vecs[v].exp_src));
      check($sformatf("vec%0d_act", v), 32'(active), 32'(vecs[v].exp_act));
      clear_all();
    end
    bright = 3'd0;

    // One-cycle pulse on source 1 is stretched
    src_req = 4'b0010;
    step("pulse");
    src_req = '0;
    step("pulse");
    check("pulse_color", 32'(color), 32'h00FF00);
    check("pulse_src", 32'(active_src), 32'd1);
    dur  = 1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step("pulse_hold");
      dur++;
      if (color == IDLE_COLOR) seen = 1'b1;
    end
    check("pulse_expired", 32'(seen), 32'd1);
    check("pulse_dur_ok", 32'((dur >= (HOLD_MS - 1) * TPD) && (dur <= (HOLD_MS + 1) * TPD + 2)), 32'd1);
    clear_all();

    // Source 2 over source 0, then held after drop
    src_req = 4'b0101;
    repeat (5) step("prio");
    check("prio_src2", 32'(active_src), 32'd2);
    src_req = 4'b0001;
    repeat (100) step("prio_hold");
    check("hold_src2", 32'(active_src), 32'd2);
    check("hold_color2", 32'(color), 32'h123456);
    repeat (130) step("prio_back");
    check("back_src0", 32'(active_src), 32'd0);
    check("back_color0", 32'(color), 32'hFF8040);
    clear_all();

    // Blinking source 3: equal lit/dark time over two full periods
    src_req   = 4'b1000;
    src_blink = 4'b1000;
    step("blink_sel");
    lit_n  = 0;
    dark_n = 0;
    for (int i = 0; i < 200; i++) begin
      step("blink");
      if (i == 0) check("blink_first_lit", 32'(color), 32'h0000FF);
      if (color == 24'h0000FF) lit_n++;
      else if (color == 24'h000000) dark_n++;
    end
    check("blink_lit", 32'(lit_n), 32'd100);
    check("blink_dark", 32'(dark_n), 32'd100);
    clear_all();

    // Switch from source 1 to blinking source 3 restarts lit
    src_req = 4'b0010;
    repeat (76) step("sw_pre");
    src_req = 4'b1010;
    step("sw");
    step("sw");
    check("switch_lit", 32'(color), 32'h0000FF);
    check("switch_src", 32'(active_src), 32'd3);
    repeat (60) step("sw_run");
    src_blink = '0;
    clear_all();

    // Reset mid-hold clears outputs asynchronously, no stale colour after
    src_req = 4'b0100;
    step("mid");
    src_req = '0;
    repeat (50) step("mid_hold");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_color", 32'(color), 32'h0);
    check("async_active", 32'(active), 32'h0);
    check("async_src", 32'(active_src), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step("post_rst");
    step("post_rst");
    check("post_rst_idle", 32'(color), 32'(IDLE_COLOR));
    check("post_rst_act", 32'(active), 32'h0);
    repeat (50) step("post_rst_run");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if ($urandom_range(0, 99) < 2) src_req[i] = ~src_req[i];
        if ($urandom_range(0, 199) == 0) src_color[24*i +: 24] = 24'($urandom);
        if ($urandom_range(0, 199) == 0) src_blink[i] = ~src_blink[i];
      end
      if ($urandom_range(0, 99) == 0) bright = 3'($urandom_range(0, 7));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
